// File: rtl/datapath_ctrl_if.sv
// Control bundle between the instruction/sequencer block and the 16-bit datapath.
// master = controller side, slave = datapath/stimulus side.
interface datapath_ctrl_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] in_ir;
  logic              load_ir;
  logic              s;
  logic              w;
  logic              illegal;
  logic [DATA_W-1:0] datapath_in;
  logic              vsel;
  logic [2:0]        writenum;
  logic              write;
  logic [2:0]        readnum;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic [1:0]        shift;
  logic              asel;
  logic              bsel;
  logic [1:0]        ALUop;

  modport master (
    input  in_ir, load_ir, s,
    output w, illegal, datapath_in, vsel, writenum, write, readnum,
           loada, loadb, loadc, loads, shift, asel, bsel, ALUop
  );

  modport slave (
    output in_ir, load_ir, s,
    input  w, illegal, datapath_in, vsel, writenum, write, readnum,
           loada, loadb, loadc, loads, shift, asel, bsel, ALUop
  );
endinterface

// File: rtl/datapath_ctrl.sv
// Instruction register plus Moore sequencer driving the 16-bit datapath controls.
// Define CTRL_ILLEGAL_TRAP_EN to trap undefined opcodes in HALT until reset.
module datapath_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  datapath_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_COMPUTE   = 3'd5,
    S_WRITE_REG = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;
  logic       is_mov_imm, is_mov_reg, is_mvn, is_add, is_cmp, is_and, is_legal;

  always_comb begin
    opcode     = ir_q[15:13];
    op         = ir_q[12:11];
    rn         = ir_q[10:8];
    rd         = ir_q[7:5];
    sh         = ir_q[4:3];
    rm         = ir_q[2:0];
    is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    is_mvn     = (opcode == 3'b101) && (op == 2'b11);
    is_add     = (opcode == 3'b101) && (op == 2'b00);
    is_cmp     = (opcode == 3'b101) && (op == 2'b01);
    is_and     = (opcode == 3'b101) && (op == 2'b10);
    is_legal   = is_mov_imm | is_mov_reg | is_mvn | is_add | is_cmp | is_and;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // IR is only writable while idle so an instruction in flight never changes under us
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (bus.load_ir) ir_d = bus.in_ir;
        if (bus.s)       state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)                  state_d = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn)   state_d = S_GET_B;
        else if (is_add || is_cmp || is_and) state_d = S_GET_A;
        else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_COMPUTE;
      S_COMPUTE:   state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_WAIT;
    endcase
  end

  logic       w, illegal, vsel, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0] writenum, readnum;
  logic [1:0] shift, alu_op;

  always_comb begin
    w        = 1'b0;
    illegal  = 1'b0;
    vsel     = 1'b0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    writenum = 3'd0;
    readnum  = 3'd0;
    shift    = 2'b00;
    alu_op   = 2'b00;
    case (state_q)
      S_WAIT:   w = 1'b1;
      S_DECODE: illegal = ~is_legal;
      S_WRITE_IMM: begin
        vsel     = 1'b1;
        write    = 1'b1;
        writenum = rn;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        shift   = sh;
      end
      S_COMPUTE: begin
        shift = sh;
        if (is_cmp) begin
          alu_op = 2'b01;
          loads  = 1'b1;
        end else begin
          loadc = 1'b1;
          if (is_mov_reg) asel = 1'b1;
          if (is_mvn)     alu_op = 2'b11;
          if (is_and)     alu_op = 2'b10;
        end
      end
      S_WRITE_REG: begin
        write    = 1'b1;
        writenum = rd;
      end
      S_HALT:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign bus.w           = w;
  assign bus.illegal     = illegal;
  assign bus.datapath_in = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign bus.vsel        = vsel;
  assign bus.writenum    = writenum;
  assign bus.write       = write;
  assign bus.readnum     = readnum;
  assign bus.loada       = loada;
  assign bus.loadb       = loadb;
  assign bus.loadc       = loadc;
  assign bus.loads       = loads;
  assign bus.shift       = shift;
  assign bus.asel        = asel;
  assign bus.bsel        = bsel;
  assign bus.ALUop       = alu_op;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: an instruction-level model expands each
// started instruction into its per-cycle control vectors; a monitor compares them.
module tb_datapath_ctrl;

  logic clk;
  logic reset;

  datapath_ctrl_if bus();

  datapath_ctrl #(.DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic        illegal;
    logic [15:0] dp_in;
    logic        vsel;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  aluop;
  } vec_t;

  vec_t        sb[$];     // expected outputs, one per cycle, consumed by the monitor
  vec_t        pend[$];   // remaining cycles of the instruction in flight
  logic [15:0] mir;
  bit          halted;
  int          vectors;
  int          miscompares;
  bit          drv_done;

  function automatic vec_t base(input logic [15:0] ir);
    vec_t v;
    v = '0;
    v.dp_in = {{8{ir[7]}}, ir[7:0]};
    return v;
  endfunction

  // Instruction semantics as a list of control vectors, one per busy cycle
  task automatic build_seq(input logic [15:0] ir);
    vec_t dec, ga, gb, cm, wr;
    logic [4:0] key;
    key = ir[15:11];
    dec = base(ir);
    ga  = base(ir); ga.readnum = ir[10:8]; ga.loada = 1'b1;
    gb  = base(ir); gb.readnum = ir[2:0];  gb.loadb = 1'b1; gb.shift = ir[4:3];
    cm  = base(ir); cm.shift = ir[4:3];
    wr  = base(ir); wr.write = 1'b1; wr.writenum = ir[7:5];
    case (key)
      5'b11010: begin
        wr = base(ir); wr.vsel = 1'b1; wr.write = 1'b1; wr.writenum = ir[10:8];
        pend.push_back(dec); pend.push_back(wr);
      end
      5'b11000: begin
        cm.asel = 1'b1; cm.loadc = 1'b1;
        pend.push_back(dec); pend.push_back(gb); pend.push_back(cm); pend.push_back(wr);
      end
      5'b10111: begin
        cm.aluop = 2'b11; cm.loadc = 1'b1;
        pend.push_back(dec); pend.push_back(gb); pend.push_back(cm); pend.push_back(wr);
      end
      5'b10100, 5'b10110: begin
        cm.aluop = (key == 5'b10110) ? 2'b10 : 2'b00; cm.loadc = 1'b1;
        pend.push_back(dec); pend.push_back(ga); pend.push_back(gb);
        pend.push_back(cm); pend.push_back(wr);
      end
      5'b10101: begin
        cm.aluop = 2'b01; cm.loads = 1'b1;
        pend.push_back(dec); pend.push_back(ga); pend.push_back(gb); pend.push_back(cm);
      end
      default: begin
        dec.illegal = 1'b1;
        pend.push_back(dec);
      end
    endcase
  endtask

  // One clock of stimulus: record what this cycle must show, then set inputs for the next edge
  task automatic drive_cycle(input bit rst, input bit ld, input bit st, input logic [15:0] ir);
    vec_t exp;
    bit   idle;
    @(posedge clk);
    #1;
    idle = !halted && (pend.size() == 0);
    if (halted) begin
      exp = base(mir); exp.illegal = 1'b1;
    end else if (!idle) begin
      exp = pend.pop_front();
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (exp.illegal) halted = 1'b1;
`endif
    end else begin
      exp = base(mir); exp.w = 1'b1;
    end
    sb.push_back(exp);
    reset      = rst;
    bus.load_ir = ld;
    bus.s       = st;
    bus.in_ir   = ir;
    if (rst) begin
      pend.delete();
      mir    = 16'h0000;
      halted = 1'b0;
    end else if (idle) begin
      if (ld) mir = ir;
      if (st) build_seq(mir);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  function automatic vec_t sample();
    vec_t v;
    v.w        = bus.w;
    v.illegal  = bus.illegal;
    v.dp_in    = bus.datapath_in;
    v.vsel     = bus.vsel;
    v.writenum = bus.writenum;
    v.write    = bus.write;
    v.readnum  = bus.readnum;
    v.loada    = bus.loada;
    v.loadb    = bus.loadb;
    v.loadc    = bus.loadc;
    v.loads    = bus.loads;
    v.shift    = bus.shift;
    v.asel     = bus.asel;
    v.bsel     = bus.bsel;
    v.aluop    = bus.ALUop;
    return v;
  endfunction

  initial begin : monitor
    vec_t exp, act;
    vectors     = 0;
    miscompares = 0;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        act = sample();
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("FAIL ctrl_out t=%0t got w=%b ill=%b dp=%h vsel=%b wn=%0d wr=%b rn=%0d ld(abcs)=%b%b%b%b sh=%b as=%b bs=%b alu=%b | want w=%b ill=%b dp=%h vsel=%b wn=%0d wr=%b rn=%0d ld(abcs)=%b%b%b%b sh=%b as=%b bs=%b alu=%b",
                   $time, act.w, act.illegal, act.dp_in, act.vsel, act.writenum, act.write,
                   act.readnum, act.loada, act.loadb, act.loadc, act.loads, act.shift,
                   act.asel, act.bsel, act.aluop,
                   exp.w, exp.illegal, exp.dp_in, exp.vsel, exp.writenum, exp.write,
                   exp.readnum, exp.loada, exp.loadb, exp.loadc, exp.loads, exp.shift,
                   exp.asel, exp.bsel, exp.aluop);
        end
      end
    end
  end

  function automatic logic [15:0] rand_ir();
    logic [15:0] ir;
    logic [4:0]  keys [6];
    keys = '{5'b11010, 5'b11000, 5'b10111, 5'b10100, 5'b10101, 5'b10110};
    ir = 16'($urandom);
    if ($urandom_range(0, 3) != 0) ir[15:11] = keys[$urandom_range(0, 5)];
    return ir;
  endfunction

  initial begin : driver
    drv_done    = 1'b0;
    halted      = 1'b0;
    mir         = 16'h0000;
    reset       = 1'b1;
    bus.load_ir = 1'b0;
    bus.s       = 1'b0;
    bus.in_ir   = 16'h0000;

    drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    idle_cycles(2);

    // MOV R2,#5 : load then start on separate cycles
    drive_cycle(1'b0, 1'b1, 1'b0, 16'hD205);
    drive_cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    idle_cycles(4);
    // MOV R1,#-1 with load and start together
    drive_cycle(1'b0, 1'b1, 1'b1, 16'hD1FF);
    idle_cycles(4);
    // ADD R3,R2,R1 LSL; load/start pulses while busy must be ignored
    drive_cycle(1'b0, 1'b1, 1'b1, 16'hA269);
    drive_cycle(1'b0, 1'b1, 1'b1, 16'hAA01);
    drive_cycle(1'b0, 1'b1, 1'b1, 16'hFFFF);
    idle_cycles(5);
    // CMP R2,R1
    drive_cycle(1'b0, 1'b1, 1'b1, 16'hAA01);
    idle_cycles(5);
    // Undefined opcode
    drive_cycle(1'b0, 1'b1, 1'b1, 16'h0000);
    drive_cycle(1'b0, 1'b1, 1'b1, 16'hD205);
    idle_cycles(10);
    drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    idle_cycles(2);
    // Reset during GET_B of ADD, then restart with the cleared IR
    drive_cycle(1'b0, 1'b1, 1'b1, 16'hA269);
    idle_cycles(2);
    drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    drive_cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    idle_cycles(4);
    drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);

    for (int i = 0; i < 1500; i++) begin
      drive_cycle($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) != 0, rand_ir());
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    idle_cycles(3);
    drv_done = 1'b1;
  end

  initial begin : finisher
    wait (drv_done);
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
